unary_multi_adder: RTL and testbench

- N-input unary adder. Sums N_IN unary pulse trains that start on the same cycle and emits the total as one unary train on out.
- Successor to the two-input LIFO adder. Replaces the stack with a binary pending counter.
- Adds per-channel enable, optional output saturation, a done pulse, a binary total, and overlap detection.
- Sits in the unary shift-MAC datapath, where it merges partial-product streams.

---
 rtl/unary_pkg.sv | 18 +
 rtl/unary_popcount.sv | 19 +
 rtl/unary_multi_adder.sv | 88 ++++++++
 tb/tb_unary_multi_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared helpers and state encoding for the unary adder family.
package unary_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Counter width able to hold the sum of all channels at full length.
    function automatic int unsigned cnt_width(input int unsigned bin_bits, input int unsigned n_in);
        return bin_bits + clog2(n_in) + 1;
    endfunction

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} ustate_t;

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of an N_IN-bit vector.
module unary_popcount
    import unary_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    localparam int unsigned PC_W = clog2(N_IN + 1)
) (
    input  logic [N_IN-1:0] bits,
    output logic [PC_W-1:0] count_c
);

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            count_c = count_c + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/unary_multi_adder.sv
// N-input unary adder: merges simultaneous unary trains into one contiguous train
// using a binary pending counter, with optional length cap and completion reporting.
module unary_multi_adder
    import unary_pkg::*;
#(
    parameter int unsigned BIN_BITS = 4,
    parameter int unsigned N_IN     = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned OUT_MAX  = 2 ** (BIN_BITS + 1),
    localparam int unsigned CNT_W   = cnt_width(BIN_BITS, N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  in,
    input  logic [N_IN-1:0]  chan_en,
    output logic             out,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] sum_bin,
    output logic             saturated,
    output logic             overlap_err
);

    localparam int unsigned PC_W   = clog2(N_IN + 1);
    localparam bit          SAT_EN = (SATURATE != 0);

    ustate_t          state, state_next;
    logic [CNT_W-1:0] pending, pending_next;
    logic [CNT_W-1:0] emitted, emitted_next;
    logic [CNT_W-1:0] k, avail;
    logic [N_IN-1:0]  act;
    logic [PC_W-1:0]  raw_k;
    logic             counting, cap, cap_next, late_in;

    assign act = in & chan_en;

    unary_popcount #(.N_IN(N_IN)) u_popcount (
        .bits    (act),
        .count_c (raw_k)
    );

    // Per-cycle datapath terms and next-state selection.
    always_comb begin
        counting     = (state == IDLE) || (state == ACTIVE);
        k            = counting ? CNT_W'(raw_k) : '0;
        avail        = pending + k;
        cap          = SAT_EN && (emitted == CNT_W'(OUT_MAX));
        out          = (state != DONE) && (avail != '0) && !cap;
        emitted_next = emitted + CNT_W'(out);
        // Look ahead so the cycle carrying the last capped one already heads to DONE.
        cap_next     = SAT_EN && (emitted_next == CNT_W'(OUT_MAX));
        pending_next = cap_next ? '0 : (avail - CNT_W'(out));
        late_in      = ((state == DRAIN) || (state == DONE)) && (act != '0);
        state_next   = state;
        case (state)
            IDLE:    if (k != '0) state_next = ACTIVE;
            ACTIVE:  if (k == '0) state_next = (pending_next == '0) ? DONE : DRAIN;
            DRAIN:   if ((pending_next == '0) || cap_next) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            emitted     <= '0;
            sum_bin     <= '0;
            done        <= 1'b0;
            saturated   <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            emitted <= (state == DONE) ? '0 : emitted_next;
            done    <= (state_next == DONE);
            if (state_next == DONE) begin
                sum_bin   <= emitted_next;
                saturated <= cap_next;
            end
            if (late_in) overlap_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unary_multi_adder.sv
// Directed bench for unary_multi_adder across a 2-input, a 4-input and a saturating 2-input instance.
module tb_unary_multi_adder;

    localparam int MAX_CYC = 120;

    logic clk;
    logic reset;

    logic [1:0] in2, en2, ins, ens;
    logic [3:0] in4, en4;

    logic       out2, rdy2, done2, sat2, ovf2;
    logic [5:0] sum2;
    logic       out4, rdy4, done4, sat4, ovf4;
    logic [6:0] sum4;
    logic       outs, rdys, dones, sats, ovfs;
    logic [5:0] sums;

    int tests  = 0;
    int failed = 0;

    unary_multi_adder #(.BIN_BITS(4), .N_IN(2)) u_n2 (
        .clk(clk), .reset(reset), .in(in2), .chan_en(en2), .out(out2), .ready(rdy2),
        .done(done2), .sum_bin(sum2), .saturated(sat2), .overlap_err(ovf2)
    );

    unary_multi_adder #(.BIN_BITS(4), .N_IN(4)) u_n4 (
        .clk(clk), .reset(reset), .in(in4), .chan_en(en4), .out(out4), .ready(rdy4),
        .done(done4), .sum_bin(sum4), .saturated(sat4), .overlap_err(ovf4)
    );

    unary_multi_adder #(.BIN_BITS(4), .N_IN(2), .SATURATE(1), .OUT_MAX(10)) u_sat (
        .clk(clk), .reset(reset), .in(ins), .chan_en(ens), .out(outs), .ready(rdys),
        .done(dones), .sum_bin(sums), .saturated(sats), .overlap_err(ovfs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [3:0] v, input logic [3:0] en);
        in2 = '0; in4 = '0; ins = '0;
        case (sel)
            0: begin in2 = v[1:0]; en2 = en[1:0]; end
            1: begin in4 = v;      en4 = en;      end
            default: begin ins = v[1:0]; ens = en[1:0]; end
        endcase
    endtask

    // One operation: channel i high for lens[i] cycles from cycle 0; optional extra
    // pulse on channel 0 and optional reset cycle. Records the output train shape.
    task automatic run_op(input int sel, input int l0, input int l1, input int l2, input int l3,
                          input logic [3:0] en, input int pulse_cyc, input int rst_cyc,
                          output int ones, output int last, output int done_cyc,
                          output int sb, output int st, output int gaps);
        int lens[4];
        logic [3:0] v;
        logic o, d;
        lens = '{l0, l1, l2, l3};
        ones = 0; last = -1; done_cyc = -1; sb = -1; st = -1; gaps = 0;
        for (int c = 0; c < MAX_CYC; c++) begin
            for (int i = 0; i < 4; i++) v[i] = (c < lens[i]) || (i == 0 && c == pulse_cyc);
            drive(sel, v, en);
            reset = (c == rst_cyc);
            @(negedge clk);
            case (sel)
                0:       begin o = out2; d = done2; end
                1:       begin o = out4; d = done4; end
                default: begin o = outs; d = dones; end
            endcase
            if (o) begin
                if ((ones == 0 && c != 0) || (ones > 0 && last != c - 1)) gaps++;
                ones++;
                last = c;
            end
            if (d && done_cyc < 0) begin
                done_cyc = c;
                case (sel)
                    0:       begin sb = int'(sum2); st = int'(sat2); end
                    1:       begin sb = int'(sum4); st = int'(sat4); end
                    default: begin sb = int'(sums); st = int'(sats); end
                endcase
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0 || c == rst_cyc) break;
        end
        drive(sel, 4'b0000, en);
        reset = 1'b0;
    endtask

    int ones, last, dcyc, sb, st, gaps;

    initial begin
        reset = 1'b1;
        in2 = '0; in4 = '0; ins = '0;
        en2 = 2'b11; en4 = 4'b1111; ens = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rdy4), 1);
        check("rst_out", 32'(out4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_sum", 32'(sum4), 0);
        check("rst_ovf", 32'(ovf4), 0);
        check("rst_ready_sat", 32'(rdys), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 3 + 5 on the 2-input instance
        run_op(0, 3, 5, 0, 0, 4'b0011, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t1_ones", ones, 8);
        check("t1_last", last, 7);
        check("t1_gaps", gaps, 0);
        check("t1_done_cyc", dcyc, 8);
        check("t1_sum", sb, 8);
        check("t1_sat", st, 0);
        @(negedge clk);
        check("t1_ready_after", 32'(rdy2), 1);
        check("t1_sum_hold", 32'(sum2), 8);
        @(posedge clk); #1;

        // four full-length channels
        run_op(1, 16, 16, 16, 16, 4'b1111, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t2_ones", ones, 64);
        check("t2_last", last, 63);
        check("t2_gaps", gaps, 0);
        check("t2_done_cyc", dcyc, 64);
        check("t2_sum", sb, 64);

        // saturating instance, 8 + 8 capped at 10
        run_op(2, 8, 8, 0, 0, 4'b0011, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t3_ones", ones, 10);
        check("t3_last", last, 9);
        check("t3_done_cyc", dcyc, 10);
        check("t3_sum", sb, 10);
        check("t3_sat", st, 1);
        @(negedge clk);
        check("t3_ready_c11", 32'(rdys), 1);
        check("t3_out_c11", 32'(outs), 0);
        @(posedge clk); #1;
        // leftover pending would lengthen this train if it had not been cleared
        run_op(2, 2, 1, 0, 0, 4'b0011, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t3b_ones", ones, 3);
        check("t3b_done_cyc", dcyc, 3);
        check("t3b_sum", sb, 3);
        check("t3b_sat", st, 0);

        // only channels 0 and 2 enabled
        run_op(1, 4, 4, 4, 4, 4'b0101, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t4_ones", ones, 8);
        check("t4_gaps", gaps, 0);
        check("t4_sum", sb, 8);
        check("t4_ovf_clear", 32'(ovf4), 0);

        // 6 + 6 with a stray pulse on channel 0 while draining
        run_op(1, 6, 6, 0, 0, 4'b1111, 8, -1, ones, last, dcyc, sb, st, gaps);
        check("t5_ones", ones, 12);
        check("t5_done_cyc", dcyc, 12);
        check("t5_sum", sb, 12);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_ovf_sticky", 32'(ovf4), 1);
        @(posedge clk); #1;

        // reset during DRAIN, then a fresh 2 + 2
        run_op(1, 6, 6, 0, 0, 4'b1111, -1, 8, ones, last, dcyc, sb, st, gaps);
        check("t6_no_done", dcyc, -1);
        @(negedge clk);
        check("t6_out_after_rst", 32'(out4), 0);
        check("t6_ready_after_rst", 32'(rdy4), 1);
        check("t6_done_after_rst", 32'(done4), 0);
        check("t6_ovf_after_rst", 32'(ovf4), 0);
        @(posedge clk); #1;
        run_op(1, 2, 2, 0, 0, 4'b1111, -1, -1, ones, last, dcyc, sb, st, gaps);
        check("t6_ones", ones, 4);
        check("t6_done_cyc", dcyc, 4);
        check("t6_sum", sb, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
